adc_frame_sampler: RTL

Downstream consumer of the ADC trigger stage in the FCML control path. It takes the trigger (`dpwm_s`) and the carrier-valley update strobe (`updateo`). Each trigger rising edge starts one serial read of an external 12-bit SPI ADC (CS/SCLK/SDO, CPOL=1, MSB first, leading zeros). Each update rising edge closes a sample window and hands the window sum and count to the control loop.

---
 rtl/fcml_adc_pkg.sv | 23 ++
 rtl/adc_frame_sampler_if.sv | 35 +++
 rtl/spi_adc_rx.sv | 85 ++++++++
 rtl/adc_frame_sampler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fcml_adc_pkg.sv
// Shared definitions for the FCML ADC sampling path: FSM state encoding,
// default parameter values and the window-sum width helper.
package fcml_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } adc_state_e;

    localparam int DEF_SCLK_DIV   = 4;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_DATA_BITS  = 12;
    localparam int DEF_QUIET_CYC  = 8;
    localparam int DEF_CNT_W      = 4;

    // Window sum needs DATA_BITS plus one bit per counter bit so that
    // 2^CNT_W-1 full-scale samples can never wrap.
    function automatic int win_sum_width(input int data_bits, input int cnt_w);
        return data_bits + cnt_w;
    endfunction

endpackage

// File: rtl/adc_frame_sampler_if.sv
// Signal bundle between the ADC frame sampler and its environment:
// trigger/update inputs, the SPI ADC pins and the window results.
interface adc_frame_sampler_if #(
    parameter int DATA_BITS = fcml_adc_pkg::DEF_DATA_BITS,
    parameter int CNT_W     = fcml_adc_pkg::DEF_CNT_W
);
    localparam int SUM_W = fcml_adc_pkg::win_sum_width(DATA_BITS, CNT_W);

    logic                 trig;
    logic                 update;
    logic                 adc_sdo;
    logic                 adc_cs_n;
    logic                 adc_sclk;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic [SUM_W-1:0]     win_sum;
    logic [CNT_W-1:0]     win_cnt;
    logic                 win_valid;
    logic                 overrun;

    // Sampler side
    modport master (
        input  trig, update, adc_sdo,
        output adc_cs_n, adc_sclk, sample, sample_valid,
               win_sum, win_cnt, win_valid, overrun
    );

    // Environment side (trigger source, ADC, control loop)
    modport slave (
        output trig, update, adc_sdo,
        input  adc_cs_n, adc_sclk, sample, sample_valid,
               win_sum, win_cnt, win_valid, overrun
    );

endinterface

// File: rtl/spi_adc_rx.sv
// SPI receive engine for a CPOL=1, MSB-first serial ADC: SCLK divider,
// shift register and rising-edge counter. A start pulse launches one frame;
// done pulses together with the last SCLK rising edge, data valid with it.
module spi_adc_rx #(
    parameter int SCLK_DIV   = fcml_adc_pkg::DEF_SCLK_DIV,
    parameter int FRAME_BITS = fcml_adc_pkg::DEF_FRAME_BITS,
    parameter int DATA_BITS  = fcml_adc_pkg::DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sdo,
    output logic                 sclk,
    output logic                 done,
    output logic [DATA_BITS-1:0] data
);
    localparam int DIV_W = $clog2(SCLK_DIV) + 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    logic                 active_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic                 sclk_r;
    logic                 done_r;
    // Only the trailing DATA_BITS bits of a frame are ever used, so the
    // leading bits are allowed to fall off the top of the register.
    logic [DATA_BITS-1:0] shift_r;

    logic tick_s;
    logic rise_s;
    logic last_s;

    // Divider terminal count, SCLK rising-edge and final-edge decode
    always_comb begin
        tick_s = active_r && (div_cnt_r == DIV_W'(SCLK_DIV - 1));
        rise_s = tick_s && !sclk_r;
        last_s = rise_s && (bit_cnt_r == BIT_W'(FRAME_BITS - 1));
    end

    // Frame sequencing: divider, SCLK toggle, sampling on SCLK rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r  <= 1'b0;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            sclk_r    <= 1'b1;
            done_r    <= 1'b0;
            shift_r   <= '0;
        end else begin
            done_r <= last_s;
            if (start) begin
                active_r  <= 1'b1;
                div_cnt_r <= '0;
                bit_cnt_r <= '0;
                sclk_r    <= 1'b1;
                shift_r   <= '0;
            end else if (active_r) begin
                if (tick_s) begin
                    div_cnt_r <= '0;
                    sclk_r    <= ~sclk_r;
                    if (rise_s) begin
                        shift_r   <= (shift_r << 1) | DATA_BITS'(sdo);
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                    if (last_s) begin
                        active_r <= 1'b0;
                    end else begin
                        active_r <= 1'b1;
                    end
                end else begin
                    div_cnt_r <= div_cnt_r + DIV_W'(1);
                end
            end else begin
                div_cnt_r <= '0;
            end
        end
    end

    assign sclk = sclk_r;
    assign done = done_r;
    assign data = shift_r;

endmodule

// File: rtl/adc_frame_sampler.sv
// ADC frame sampler: converts trigger rising edges into SPI ADC reads and
// accumulates the results into windows closed by update rising edges.
module adc_frame_sampler
    import fcml_adc_pkg::*;
#(
    parameter int SCLK_DIV   = DEF_SCLK_DIV,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int QUIET_CYC  = DEF_QUIET_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    adc_frame_sampler_if.master bus
);
    localparam int SUM_W   = win_sum_width(DATA_BITS, CNT_W);
    localparam int QUIET_W = $clog2(QUIET_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 trig_r;
    logic                 update_r;
    adc_state_e           state_r;
    logic [QUIET_W-1:0]   quiet_cnt_r;
    logic                 cs_n_r;
    logic [DATA_BITS-1:0] sample_r;
    logic                 sample_valid_r;
    logic [SUM_W-1:0]     acc_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [SUM_W-1:0]     win_sum_r;
    logic [CNT_W-1:0]     win_cnt_r;
    logic                 win_valid_r;
    logic                 overrun_r;

    logic                 trig_edge_s;
    logic                 update_edge_s;
    logic                 start_s;
    logic                 lost_trig_s;
    logic                 sat_s;
    logic [SUM_W-1:0]     acc_next_s;
    logic [CNT_W-1:0]     cnt_next_s;
    logic                 rx_done_s;
    logic [DATA_BITS-1:0] rx_data_s;
    logic                 rx_sclk_s;

    spi_adc_rx #(
        .SCLK_DIV   (SCLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .DATA_BITS  (DATA_BITS)
    ) u_rx (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .sdo   (bus.adc_sdo),
        .sclk  (rx_sclk_s),
        .done  (rx_done_s),
        .data  (rx_data_s)
    );

    // Edge decode and window arithmetic including a finishing sample
    always_comb begin
        trig_edge_s   = bus.trig & ~trig_r;
        update_edge_s = bus.update & ~update_r;
        start_s       = trig_edge_s && (state_r == ST_IDLE);
        lost_trig_s   = trig_edge_s && (state_r != ST_IDLE);
        acc_next_s    = acc_r;
        cnt_next_s    = cnt_r;
        sat_s         = 1'b0;
        if (rx_done_s) begin
            if (cnt_r == CNT_MAX) begin
                sat_s = 1'b1;
            end else begin
                acc_next_s = acc_r + SUM_W'(rx_data_s);
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            sat_s = 1'b0;
        end
    end

    // Previous-value registers for trig/update edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_r   <= 1'b0;
            update_r <= 1'b0;
        end else begin
            trig_r   <= bus.trig;
            update_r <= bus.update;
        end
    end

    // Conversion FSM: chip select and the post-frame quiet interval
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cs_n_r      <= 1'b1;
            quiet_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_CONV;
                        cs_n_r  <= 1'b0;
                    end else begin
                        cs_n_r  <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (rx_done_s) begin
                        state_r     <= ST_QUIET;
                        cs_n_r      <= 1'b1;
                        quiet_cnt_r <= '0;
                    end else begin
                        cs_n_r      <= 1'b0;
                    end
                end
                ST_QUIET: begin
                    if (quiet_cnt_r == QUIET_W'(QUIET_CYC - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        quiet_cnt_r <= quiet_cnt_r + QUIET_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_n_r  <= 1'b1;
                end
            endcase
        end
    end

    // Latest conversion result and its strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_r       <= '0;
            sample_valid_r <= 1'b0;
        end else begin
            sample_valid_r <= rx_done_s;
            if (rx_done_s) begin
                sample_r <= rx_data_s;
            end else begin
                sample_r <= sample_r;
            end
        end
    end

    // Window accumulation, hand-off on update and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            win_sum_r   <= '0;
            win_cnt_r   <= '0;
            win_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            win_valid_r <= update_edge_s;
            if (update_edge_s) begin
                // Closing window takes the finishing sample; a trigger lost
                // on this same cycle is charged to the new window.
                win_sum_r <= acc_next_s;
                win_cnt_r <= cnt_next_s;
                acc_r     <= '0;
                cnt_r     <= '0;
                overrun_r <= lost_trig_s;
            end else begin
                acc_r     <= acc_next_s;
                cnt_r     <= cnt_next_s;
                overrun_r <= overrun_r | lost_trig_s | sat_s;
            end
        end
    end

    assign bus.adc_cs_n     = cs_n_r;
    assign bus.adc_sclk     = rx_sclk_s;
    assign bus.sample       = sample_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.win_sum      = win_sum_r;
    assign bus.win_cnt      = win_cnt_r;
    assign bus.win_valid    = win_valid_r;
    assign bus.overrun      = overrun_r;

endmodule
